// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D); D wins ties, and a starvation counter forces an I grant.
// Latency: a request sampled in cycle 0 issues mem_req in cycle 1; with a 0-wait memory, ack arrives in cycle 2 (3 cycles per access minimum).
// Backpressure: requesters hold their req level until their ack; the memory stalls by delaying mem_ack.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STARVE_MAX = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    sel,
    output logic                    busy
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic          owner;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          grant_d, grant_i;

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            IDLE: begin
                // With STARVE_MAX=0 the limit is always reached, so I wins every tie.
                if (d_req && !(i_req && (starve_cnt == STARVE_LIM))) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY;
                    if (!i_req)
                        starve_nxt = '0;
                    else if (starve_cnt != STARVE_LIM)
                        starve_nxt = starve_cnt + CW'(1);
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_nxt  = BUSY;
                    starve_nxt = '0;
                end
            end
            BUSY: if (mem_ack) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            owner      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (grant_d) begin
                owner     <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
            end else if (grant_i) begin
                owner     <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_wstrb <= {SW{1'b0}};
            end
            // Read data is captured for stores too; acks outside BUSY never touch it.
            if (state == BUSY && mem_ack) begin
                if (owner)
                    d_rdata <= mem_rdata;
                else
                    i_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req = (state == BUSY);
    assign busy    = (state != IDLE);
    assign sel     = busy && owner;
    assign i_ack   = (state == DONE) && !owner;
    assign d_ack   = (state == DONE) && owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default instance (STARVE_MAX=2) and a STARVE_MAX=0 instance share the stimulus.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wstrb;

    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        i_ack, d_ack, mem_req, mem_we, sel, busy;

    logic [31:0] z_i_rdata, z_d_rdata, z_mem_addr, z_mem_wdata;
    logic [3:0]  z_mem_wstrb;
    logic        z_i_ack, z_d_ack, z_mem_req, z_mem_we, z_sel, z_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .sel(sel), .busy(busy)
    );

    mem_port_arbiter #(.STARVE_MAX(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(z_i_rdata), .i_ack(z_i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(z_d_rdata), .d_ack(z_d_ack),
        .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_wstrb(z_mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .sel(z_sel), .busy(z_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({mem_req, sel, busy, i_ack, d_ack, mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000", {mem_req, sel, busy, i_ack, d_ack, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata} !== 132'b0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h ird=%h drd=%h want all 0",
                     mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        i_req = 1'b1; i_addr = 32'h100; mem_rdata = 32'h13; mem_ack = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, sel, busy, mem_we, i_ack} !== 5'b10100 || mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL fetch_busy: req/sel/busy/we/ack=%b addr=%h want 10100 addr=100",
                     {mem_req, sel, busy, mem_we, i_ack}, mem_addr);
        end
        tick();
        n_checks++;
        if ({i_ack, d_ack, mem_req, sel} !== 4'b1000 || i_rdata !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_done: iack/dack/req/sel=%b rdata=%h want 1000 rdata=13",
                     {i_ack, d_ack, mem_req, sel}, i_rdata);
        end
        i_req = 1'b0; mem_ack = 1'b0;
        tick();
        n_checks++;
        if ({i_ack, busy} !== 2'b00 || i_rdata !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_idle: iack/busy=%b rdata=%h want 00 rdata=13", {i_ack, busy}, i_rdata);
        end
    endtask

    task automatic test_store_wait();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        mem_rdata = 32'hAAAA5555; mem_ack = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({mem_req, mem_we, sel, d_ack} !== 4'b1110 || mem_addr !== 32'h2000 ||
                mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'b0011) begin
                n_fail++;
                $display("FAIL store_busy%0d: req/we/sel/ack=%b addr=%h wdata=%h wstrb=%b want 1110 2000 deadbeef 0011",
                         k, {mem_req, mem_we, sel, d_ack}, mem_addr, mem_wdata, mem_wstrb);
            end
            if (k == 3) mem_ack = 1'b1;
            tick();
        end
        n_checks++;
        if ({d_ack, i_ack, sel, mem_req} !== 4'b1010 || d_rdata !== 32'hAAAA5555) begin
            n_fail++;
            $display("FAIL store_done: dack/iack/sel/req=%b rdata=%h want 1010 aaaa5555",
                     {d_ack, i_ack, sel, mem_req}, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        tick();
        n_checks++;
        if ({d_ack, sel, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL store_idle: dack/sel/busy=%b want 000", {d_ack, sel, busy});
        end
    endtask

    task automatic test_starvation();
        logic [5:0] seq;
        int         n_got, n_both;
        seq = '0; n_got = 0; n_both = 0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h80; mem_ack = 1'b1;
        for (int c = 0; c < 60 && n_got < 6; c++) begin
            tick();
            if (i_ack && d_ack) n_both++;
            if (i_ack || d_ack) begin
                seq = {seq[4:0], d_ack};
                n_got++;
            end
        end
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        n_checks++;
        if (n_got !== 6) begin
            n_fail++;
            $display("FAIL starve_count: got %0d acks want 6 within budget", n_got);
        end
        n_checks++;
        if (seq !== 6'b110110) begin
            n_fail++;
            $display("FAIL starve_order: got %b want 110110 (1=D,0=I)", seq);
        end
        n_checks++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL starve_overlap: %0d cycles with both acks want 0", n_both);
        end
        tick();
        tick();
    endtask

    task automatic test_starve_zero();
        logic [1:0] acks;
        test_reset();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ack = 1'b1;
        tick();
        n_checks++;
        if ({z_mem_req, z_sel} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_grant: req/sel=%b want 10", {z_mem_req, z_sel});
        end
        for (int ph = 0; ph < 2; ph++) begin
            acks = 2'b00;
            for (int c = 0; c < 20 && acks == 2'b00; c++) begin
                tick();
                acks = {z_i_ack, z_d_ack};
            end
            n_checks++;
            if (acks !== (ph == 0 ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL zero_order%0d: iack/dack=%b want %b", ph, acks, (ph == 0 ? 2'b10 : 2'b01));
            end
            if (ph == 0) i_req = 1'b0;
            else d_req = 1'b0;
        end
        mem_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_in_busy();
        int n_ack;
        n_ack = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678; d_wstrb = 4'b1111;
        mem_ack = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mem_req, sel} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstbusy_pre: req/sel=%b want 11", {mem_req, sel});
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, sel, busy, i_ack, d_ack, mem_we} !== 6'b0 ||
            {mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata} !== 132'b0) begin
            n_fail++;
            $display("FAIL rstbusy_outs: ctrl=%b addr=%h wdata=%h wstrb=%h ird=%h drd=%h want all 0",
                     {mem_req, sel, busy, i_ack, d_ack, mem_we}, mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata);
        end
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_ack || busy) n_ack++;
        end
        n_checks++;
        if (n_ack !== 0) begin
            n_fail++;
            $display("FAIL rstbusy_noack: %0d cycles with ack/busy after reset want 0", n_ack);
        end
        i_req = 1'b1; i_addr = 32'h40; mem_rdata = 32'h55; mem_ack = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, sel} !== 2'b10 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL rstbusy_fresh_busy: req/sel=%b addr=%h want 10 addr=40", {mem_req, sel}, mem_addr);
        end
        tick();
        n_checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h55) begin
            n_fail++;
            $display("FAIL rstbusy_fresh_done: iack=%b rdata=%h want 1 55", i_ack, i_rdata);
        end
        i_req = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        tick();
        n_checks++;
        if ({busy, mem_req, i_ack, d_ack} !== 4'b0000 || i_rdata !== 32'h55) begin
            n_fail++;
            $display("FAIL stray_idle: busy/req/iack/dack=%b rdata=%h want 0000 55",
                     {busy, mem_req, i_ack, d_ack}, i_rdata);
        end
        i_req = 1'b1; i_addr = 32'h44; mem_rdata = 32'h77;
        tick();
        tick();
        n_checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h77) begin
            n_fail++;
            $display("FAIL stray_done: iack=%b rdata=%h want 1 77", i_ack, i_rdata);
        end
        i_req = 1'b0; mem_rdata = 32'h99;
        tick();
        n_checks++;
        if ({busy, mem_req, i_ack} !== 3'b000 || i_rdata !== 32'h77) begin
            n_fail++;
            $display("FAIL stray_after_done: busy/req/iack=%b rdata=%h want 000 77",
                     {busy, mem_req, i_ack}, i_rdata);
        end
        tick();
        n_checks++;
        if ({busy, i_ack, d_ack} !== 3'b000 || i_rdata !== 32'h77 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL stray_idle2: busy/iack/dack=%b ird=%h drd=%h want 000 77 0",
                     {busy, i_ack, d_ack}, i_rdata, d_rdata);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
        test_reset();
        test_fetch_only();
        test_store_wait();
        test_reset();
        test_starvation();
        test_starve_zero();
        test_reset();
        test_reset_in_busy();
        test_stray_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
